// File: rtl/pwm_multichannel_gen_pkg.sv
// Shared helpers for the multi-channel PWM generator: prescale derivation, write-index width,
// and the counting-mode type used when PWM_CENTER_ALIGN_EN is defined.
package pwm_multichannel_gen_pkg;

  typedef enum logic {ModeEdge, ModeCenter} pwm_mode_e;

  // Clocks per counter tick; never below one so the counter always advances.
  function automatic int unsigned calc_res(input longint unsigned sys_freq,
                                           input longint unsigned pwm_freq,
                                           input int unsigned     bit_width);
    longint unsigned div;
    div = sys_freq / (pwm_freq * (64'd1 << bit_width));
    return (div == 64'd0) ? 32'd1 : 32'(div);
  endfunction

  function automatic int unsigned ch_idx_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_multichannel_gen_time_base.sv
// Shared time base: prescaler, period counter and commit strobe. With PWM_CENTER_ALIGN_EN
// defined it also holds the direction flop and the per-period counting mode.
module pwm_multichannel_gen_time_base
  import pwm_multichannel_gen_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned RES       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                 center_mode,
`endif
  output logic [BIT_WIDTH-1:0] cnt,
  output logic                 run,
  output logic                 commit
);

  localparam int unsigned PrescW = (RES > 1) ? $clog2(RES) : 1;
  localparam logic [BIT_WIDTH-1:0] CntMax = '1;

  logic [PrescW-1:0]    presc_q;
  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 run_q;
  logic                 tick;
  logic                 wrap;

  assign tick = (presc_q == PrescW'(RES - 1));

`ifdef PWM_CENTER_ALIGN_EN
  pwm_mode_e mode_q;
  logic      down_q, down_d;

  // Centre mode holds MAX and 0 for one extra tick each so the period is 2**(BIT_WIDTH+1).
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    down_d = down_q;
    wrap   = 1'b0;
    if (mode_q == ModeEdge) begin
      wrap = (cnt_q == CntMax);
    end else if (!down_q) begin
      if (cnt_q == CntMax) begin
        cnt_d  = cnt_q;
        down_d = 1'b1;
      end
    end else if (cnt_q == '0) begin
      cnt_d  = cnt_q;
      down_d = 1'b0;
      wrap   = 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end
`else
  assign cnt_d = cnt_q + 1'b1;
  assign wrap  = (cnt_q == CntMax);
`endif

  // First enabled clock after idle forces a commit so new duties apply from count 0.
  assign commit = en && (!run_q || (tick && wrap));

  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      presc_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      down_q  <= 1'b0;
      if (!reset) mode_q <= ModeEdge;
`endif
    end else begin
      run_q <= 1'b1;
      if (!run_q) begin
        presc_q <= '0;
        cnt_q   <= '0;
      end else if (tick) begin
        presc_q <= '0;
        cnt_q   <= cnt_d;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
`ifdef PWM_CENTER_ALIGN_EN
      if (run_q && tick) down_q <= down_d;
      if (commit) mode_q <= center_mode ? ModeCenter : ModeEdge;
`endif
    end
  end

  assign cnt = cnt_q;
  assign run = run_q;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// Multi-channel PWM generator with shadowed duty registers committed at period boundaries.
// Define PWM_CENTER_ALIGN_EN to add the center_mode port and centre-aligned counting.
module pwm_multichannel_gen
  import pwm_multichannel_gen_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PWM_FREQ  = 100,
  parameter int unsigned SYS_FREQ  = 50000000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              wr_en,
  input  logic [ch_idx_width(NUM_CH)-1:0]   wr_ch,
  input  logic [BIT_WIDTH:0]                wr_duty,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                              center_mode,
`endif
  output logic [NUM_CH-1:0]                 pwm_out,
  output logic                              period_start
);

  localparam int unsigned Res = calc_res(SYS_FREQ, PWM_FREQ, BIT_WIDTH);
  localparam int unsigned ChW = ch_idx_width(NUM_CH);

  logic [BIT_WIDTH-1:0] cnt;
  logic                 run;
  logic                 commit;
  logic                 wr_valid;

  pwm_multichannel_gen_time_base #(
    .BIT_WIDTH(BIT_WIDTH),
    .RES      (Res)
  ) u_time_base (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
`ifdef PWM_CENTER_ALIGN_EN
    .center_mode(center_mode),
`endif
    .cnt        (cnt),
    .run        (run),
    .commit     (commit)
  );

  assign wr_valid = wr_en && (32'(wr_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [BIT_WIDTH:0] shadow_q, shadow_d;
    logic [BIT_WIDTH:0] active_q;
    logic               out_q;

    // A write landing in the commit cycle is committed directly.
    assign shadow_d = (wr_valid && (wr_ch == ChW'(i))) ? wr_duty : shadow_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        shadow_q <= '0;
        active_q <= '0;
        out_q    <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        if (commit) active_q <= shadow_d;
        out_q <= en && run && ({1'b0, cnt} < active_q);
      end
    end

    assign pwm_out[i] = out_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      period_start <= 1'b0;
    end else begin
      period_start <= commit;
    end
  end

endmodule

// File: tb/tb_pwm_multichannel_gen.sv
// Directed bench for pwm_multichannel_gen (BIT_WIDTH=4, RES=1); a 3-channel copy exercises
// out-of-range write indices. Centre-aligned scenario runs only with PWM_CENTER_ALIGN_EN.
module tb_pwm_multichannel_gen;

  localparam int unsigned BW = 4;

  logic          clk = 1'b0;
  logic          reset, en, wr_en;
  logic [1:0]    wr_ch;
  logic [BW:0]   wr_duty;
`ifdef PWM_CENTER_ALIGN_EN
  logic          center_mode;
`endif
  logic [3:0]    pwm_out;
  logic          period_start;
  logic [2:0]    pwm_out3;
  logic          period_start3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_multichannel_gen #(
    .BIT_WIDTH(BW), .NUM_CH(4), .PWM_FREQ(100), .SYS_FREQ(1600)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
`ifdef PWM_CENTER_ALIGN_EN
    .center_mode(center_mode),
`endif
    .pwm_out(pwm_out), .period_start(period_start)
  );

  pwm_multichannel_gen #(
    .BIT_WIDTH(BW), .NUM_CH(3), .PWM_FREQ(100), .SYS_FREQ(1600)
  ) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
`ifdef PWM_CENTER_ALIGN_EN
    .center_mode(center_mode),
`endif
    .pwm_out(pwm_out3), .period_start(period_start3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 40);
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("FAIL wait_period_start: period_start=%b after %0d clks, required 1", period_start, n);
    end
  endtask

  task automatic test_reset();
    logic e0, ps;
    repeat (3) step();
    checks++;
    if (pwm_out !== 4'b0 || period_start !== 1'b0 || pwm_out3 !== 3'b0) begin
      failures++;
      $display("FAIL reset_state: pwm_out=%b ps=%b pwm_out3=%b, required 0", pwm_out,
               period_start, pwm_out3);
    end
    reset = 1'b1; en = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 5'd4;
    step();
    wr_en = 1'b0;
    checks++;
    if (period_start !== 1'b1 || pwm_out !== 4'b0) begin
      failures++;
      $display("FAIL forced_commit: ps=%b pwm_out=%b, required ps=1 pwm_out=0000", period_start,
               pwm_out);
    end
    for (int k = 1; k <= 32; k++) begin
      step();
      e0 = ((k - 1) % 16) < 4;
      ps = (k % 16) == 0;
      checks++;
      if (pwm_out !== {3'b000, e0} || pwm_out3 !== {2'b00, e0} || period_start !== ps) begin
        failures++;
        $display("FAIL duty4 k=%0d: pwm_out=%b pwm_out3=%b ps=%b, required %b %b %b", k, pwm_out,
                 pwm_out3, period_start, {3'b000, e0}, {2'b00, e0}, ps);
      end
    end
  endtask

  task automatic test_extremes();
    logic e0;
    wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 5'd0;
    step();
    wr_ch = 2'd2; wr_duty = 5'd16;
    step();
    wr_ch = 2'd3; wr_duty = 5'd31;
    step();
    wr_en = 1'b0;
    wait_ps();
    for (int k = 1; k <= 48; k++) begin
      step();
      e0 = ((k - 1) % 16) < 4;
      checks++;
      if (pwm_out !== {2'b11, 1'b0, e0} || pwm_out3 !== {1'b1, 1'b0, e0}) begin
        failures++;
        $display("FAIL extremes k=%0d: pwm_out=%b pwm_out3=%b, required %b %b", k, pwm_out,
                 pwm_out3, {2'b11, 1'b0, e0}, {1'b1, 1'b0, e0});
      end
    end
  endtask

  task automatic test_shadow_commit();
    int   d;
    logic e0, ps;
    for (int k = 1; k <= 48; k++) begin
      step();
      d  = (k <= 16) ? 4 : ((k <= 32) ? 12 : 8);
      e0 = ((k - 1) % 16) < d;
      ps = (k % 16) == 0;
      checks++;
      if (pwm_out !== {2'b11, 1'b0, e0} || pwm_out3 !== {1'b1, 1'b0, e0} || period_start !== ps)
      begin
        failures++;
        $display("FAIL shadow k=%0d: pwm_out=%b pwm_out3=%b ps=%b, required %b %b %b", k,
                 pwm_out, pwm_out3, period_start, {2'b11, 1'b0, e0}, {1'b1, 1'b0, e0}, ps);
      end
      // Write at cnt==6 (mid-period) and at cnt==15 (the commit cycle itself).
      wr_en   = (k == 6) || (k == 31);
      wr_ch   = 2'd0;
      wr_duty = (k == 6) ? 5'd12 : 5'd8;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic e0, e3;
    wr_en = 1'b1; wr_ch = 2'd3; wr_duty = 5'd8;
    for (int k = 1; k <= 32; k++) begin
      step();
      wr_en = 1'b0;
      e0 = ((k - 1) % 16) < 8;
      e3 = (k <= 16) ? 1'b1 : e0;
      checks++;
      if (pwm_out !== {e3, 1'b1, 1'b0, e0} || pwm_out3 !== {1'b1, 1'b0, e0}) begin
        failures++;
        $display("FAIL out_of_range k=%0d: pwm_out=%b pwm_out3=%b, required %b %b", k, pwm_out,
                 pwm_out3, {e3, 1'b1, 1'b0, e0}, {1'b1, 1'b0, e0});
      end
    end
  endtask

  task automatic test_enable();
    logic e0, e3, ps;
    repeat (7) step();
    en = 1'b0;
    step();
    wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 5'd2;
    checks++;
    if (pwm_out !== 4'b0 || pwm_out3 !== 3'b0 || period_start !== 1'b0) begin
      failures++;
      $display("FAIL en_low: pwm_out=%b pwm_out3=%b ps=%b, required 0", pwm_out, pwm_out3,
               period_start);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      wr_en = 1'b0;
      checks++;
      if (pwm_out !== 4'b0 || pwm_out3 !== 3'b0) begin
        failures++;
        $display("FAIL en_hold i=%0d: pwm_out=%b pwm_out3=%b, required 0", i, pwm_out, pwm_out3);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (period_start !== 1'b1 || pwm_out !== 4'b0) begin
      failures++;
      $display("FAIL en_restart: ps=%b pwm_out=%b, required ps=1 pwm_out=0000", period_start,
               pwm_out);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      e0 = (k - 1) < 2;
      e3 = (k - 1) < 8;
      ps = (k == 16);
      checks++;
      if (pwm_out !== {e3, 1'b1, 1'b0, e0} || pwm_out3 !== {1'b1, 1'b0, e0} ||
          period_start !== ps) begin
        failures++;
        $display("FAIL en_period k=%0d: pwm_out=%b pwm_out3=%b ps=%b, required %b %b %b", k,
                 pwm_out, pwm_out3, period_start, {e3, 1'b1, 1'b0, e0}, {1'b1, 1'b0, e0}, ps);
      end
    end
  endtask

  task automatic test_mid_reset();
    repeat (5) step();
    reset = 1'b0;
    step();
    checks++;
    if (pwm_out !== 4'b0 || pwm_out3 !== 3'b0 || period_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: pwm_out=%b pwm_out3=%b ps=%b, required 0", pwm_out, pwm_out3,
               period_start);
    end
    reset = 1'b1;
    step();
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_restart: ps=%b, required 1", period_start);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (pwm_out !== 4'b0 || pwm_out3 !== 3'b0 || period_start !== (k == 16)) begin
        failures++;
        $display("FAIL cleared_duty k=%0d: pwm_out=%b pwm_out3=%b ps=%b, required 0 0 %b", k,
                 pwm_out, pwm_out3, period_start, (k == 16));
      end
    end
  endtask

`ifdef PWM_CENTER_ALIGN_EN
  task automatic test_center();
    int   c, v;
    logic e0, ps;
    center_mode = 1'b1;
    wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 5'd4;
    step();
    wr_en = 1'b0;
    wait_ps();
    for (int k = 1; k <= 64; k++) begin
      step();
      c  = (k - 1) % 32;
      v  = (c <= 15) ? c : 31 - c;
      e0 = v < 4;
      ps = (k % 32) == 0;
      checks++;
      if (pwm_out[0] !== e0 || period_start !== ps) begin
        failures++;
        $display("FAIL center k=%0d: out0=%b ps=%b, required %b %b", k, pwm_out[0],
                 period_start, e0, ps);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0; en = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_duty = '0;
`ifdef PWM_CENTER_ALIGN_EN
    center_mode = 1'b0;
`endif
    test_reset();
    test_extremes();
    test_shadow_commit();
    test_out_of_range();
    test_enable();
    test_mid_reset();
`ifdef PWM_CENTER_ALIGN_EN
    test_center();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
